// File: rtl/proc_pkg.sv
// Shared types and constants for the 4-bit processor fetch/execute sequencer.
package proc_pkg;

    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_t;

    // Bit positions within the 7-bit decoder input word
    localparam int DEC_PHASE  = 0;
    localparam int DEC_Z      = 1;
    localparam int DEC_C      = 2;
    localparam int DEC_OP_LSB = 3;
    localparam int DEC_W      = 7;

endpackage

// File: rtl/proc_sequencer_pc_reg.sv
// Program counter: load beats increment, increment wraps modulo 2^PC_W.
module pc_reg #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (en) begin
            if (load)
                pc <= load_addr;
            else if (inc)
                pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Fetch/execute sequencer: phase FSM, PC, instruction register and C/Z flags.
// Optional single-step support is enabled by defining SEQ_SINGLE_STEP_EN.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic [INSTR_W-1:0] prog_byte,
    input  logic               dec_pc_inc,
    input  logic               dec_pc_load,
    input  logic               dec_flags_we,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               phase,
    output logic [DEC_W-1:0]   dec_in,
    output logic               c_flag,
    output logic               z_flag,
    output logic               halted
);

    seq_state_t state;
    logic       start;

`ifdef SEQ_SINGLE_STEP_EN
    // A step only matters from STOP; run alone keeps EXEC looping back to FETCH,
    // so a step without run naturally yields exactly one FETCH+EXEC pair.
    assign start = run | step;
`else
    logic step_unused;
    assign step_unused = step;
    assign start = run;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_STOP;
            phase  <= 1'b0;
            halted <= 1'b1;
        end else begin
            case (state)
                ST_STOP: begin
                    if (start) begin
                        state  <= ST_FETCH;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                    phase <= 1'b1;
                end
                ST_EXEC: begin
                    phase <= 1'b0;
                    if (run) begin
                        state <= ST_FETCH;
                    end else begin
                        state  <= ST_STOP;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_STOP;
                    phase  <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instr <= '0;
        else if (state == ST_FETCH)
            instr <= prog_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (state == ST_EXEC && dec_flags_we) begin
            c_flag <= alu_c;
            z_flag <= alu_z;
        end
    end

    pc_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (state != ST_STOP),
        .load      (dec_pc_load),
        .inc       (dec_pc_inc),
        .load_addr (jump_addr),
        .pc        (pc)
    );

    always_comb begin
        dec_in                   = '0;
        dec_in[DEC_PHASE]        = phase;
        dec_in[DEC_Z]            = z_flag;
        dec_in[DEC_C]            = c_flag;
        dec_in[DEC_OP_LSB +: 4]  = instr[INSTR_W-1 -: 4];
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small asynchronous ROM model.
module tb_proc_sequencer;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, step;
    logic [7:0]  prog_byte;
    logic        dec_pc_inc, dec_pc_load, dec_flags_we;
    logic [11:0] jump_addr;
    logic        alu_c, alu_z;
    logic [11:0] pc;
    logic [7:0]  instr;
    logic        phase;
    logic [6:0]  dec_in;
    logic        c_flag, z_flag, halted;

    logic [7:0]  rom [0:4095];
    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;
    assign prog_byte = rom[pc];

    proc_sequencer #(.PC_W(12), .INSTR_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .step         (step),
        .prog_byte    (prog_byte),
        .dec_pc_inc   (dec_pc_inc),
        .dec_pc_load  (dec_pc_load),
        .dec_flags_we (dec_flags_we),
        .jump_addr    (jump_addr),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .pc           (pc),
        .instr        (instr),
        .phase        (phase),
        .dec_in       (dec_in),
        .c_flag       (c_flag),
        .z_flag       (z_flag),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0] = 8'h3A; rom[1] = 8'h51; rom[2] = 8'h6C; rom[3] = 8'h7E;
        rom[12'h123] = 8'h9F;

        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        dec_pc_inc = 1'b0; dec_pc_load = 1'b0; dec_flags_we = 1'b0;
        jump_addr = '0; alu_c = 1'b0; alu_z = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_phase", phase, 0);
        chk("rst_halted", halted, 1);
        chk("rst_dec_in", dec_in, 0);
        chk("rst_flags", {c_flag, z_flag}, 0);
        reset_n = 1'b1;
        tick();
        chk("stop_hold", halted, 1);

        // First instruction
        run = 1'b1;
        tick();
        chk("c1_phase", phase, 0);
        chk("c1_halted", halted, 0);
        tick();
        chk("c2_instr", instr, 8'h3A);
        chk("c2_phase", phase, 1);
        chk("c2_dec_in", dec_in, 7'b0011001);
        chk("c2_pc", pc, 0);
        tick();
        chk("c3_phase", phase, 0);

        // Increment in FETCH over four instructions
        for (int i = 0; i < 4; i++) begin
            dec_pc_inc = 1'b1;
            tick();
            chk("inc_pc", pc, i + 1);
            chk("inc_instr", instr, rom[i]);
            dec_pc_inc = 1'b0;
            tick();
        end

        // Preload 0xFFF then wrap
        dec_pc_load = 1'b1; jump_addr = 12'hFFF;
        tick();
        chk("preload_pc", pc, 12'hFFF);
        dec_pc_load = 1'b0; dec_pc_inc = 1'b1;
        tick();
        chk("wrap_pc", pc, 0);
        dec_pc_inc = 1'b0;

        // Load beats increment in EXEC
        tick();
        chk("exec_phase", phase, 1);
        dec_pc_load = 1'b1; dec_pc_inc = 1'b1; jump_addr = 12'h123;
        tick();
        chk("load_prio_pc", pc, 12'h123);
        dec_pc_load = 1'b0; dec_pc_inc = 1'b0;

        // Flag strobe in FETCH ignored, in EXEC captured
        dec_flags_we = 1'b1; alu_c = 1'b1; alu_z = 1'b0;
        tick();
        chk("flags_fetch_ign", {c_flag, z_flag}, 2'b00);
        tick();
        chk("flags_exec_cz", {c_flag, z_flag}, 2'b10);
        dec_flags_we = 1'b0;
        tick();
        chk("dec_in_exec", dec_in, 7'b1001101);
        chk("instr_9f", instr, 8'h9F);
        dec_flags_we = 1'b1; alu_c = 1'b0; alu_z = 1'b1;
        tick();
        chk("flags_exec_z", {c_flag, z_flag}, 2'b01);
        chk("dec_in_fetch", dec_in, 7'b1001010);
        dec_flags_we = 1'b0;

        // run drops during FETCH: EXEC completes then STOP
        run = 1'b0;
        tick();
        chk("drop_exec_phase", phase, 1);
        chk("drop_exec_halted", halted, 0);
        tick();
        chk("drop_stop_halted", halted, 1);
        chk("drop_stop_phase", phase, 0);
        dec_pc_inc = 1'b1; dec_pc_load = 1'b1; jump_addr = 12'h555;
        dec_flags_we = 1'b1; alu_c = 1'b1; alu_z = 1'b0;
        tick(); tick();
        chk("stop_pc_frozen", pc, 12'h123);
        chk("stop_flags_frozen", {c_flag, z_flag}, 2'b01);
        dec_pc_inc = 1'b0; dec_pc_load = 1'b0; dec_flags_we = 1'b0;

        // Step pulse from STOP
        step = 1'b1;
        tick();
        step = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        chk("step_fetch", {halted, phase}, 2'b00);
        tick();
        chk("step_exec", {halted, phase}, 2'b01);
        tick();
        chk("step_back_stop", {halted, phase}, 2'b10);
`else
        chk("step_ignored", halted, 1);
        tick();
        chk("step_ignored2", halted, 1);
`endif

        // Restart and async reset mid-EXEC
        run = 1'b1;
        tick();
        tick();
        chk("pre_rst_phase", phase, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_instr", instr, 0);
        chk("arst_phase", phase, 0);
        chk("arst_dec_in", dec_in, 0);
        chk("arst_flags", {c_flag, z_flag}, 0);
        chk("arst_halted", halted, 1);
        reset_n = 1'b1;
        tick();
        chk("restart_fetch", {halted, phase}, 2'b00);
        tick();
        chk("restart_instr", instr, 8'h3A);
        chk("restart_pc", pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Fetch/execute controller for the 4-bit processor core. It owns the phase flip-flop, program counter, instruction register and C/Z flag register. It assembles the 7-bit word that drives the instruction decoder, `{opcode[3:0], C, Z, phase}`, and applies the decoder's PC and flag strobes. It sits between program ROM, decoder and ALU, and sequences every instruction as one FETCH cycle followed by one EXEC cycle.

## Interface
Parameters:
- `PC_W`, 12, program-counter / ROM address width
- `INSTR_W`, 8, instruction width; opcode = `instr[INSTR_W-1 -: 4]`, operand = low 4 bits

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; 1 = free-running sequencing, 0 = stop at next FETCH boundary
- `step`  in  1  single-cycle pulse; advances one instruction while stopped (`SEQ_SINGLE_STEP_EN` only, otherwise ignored)
- `prog_byte`  in  INSTR_W  ROM data at address `pc`
- `dec_pc_inc`  in  1  decoder strobe: increment PC
- `dec_pc_load`  in  1  decoder strobe: load PC from `jump_addr`
- `dec_flags_we`  in  1  decoder strobe: capture `alu_c`/`alu_z`
- `jump_addr`  in  PC_W  branch target
- `alu_c`, `alu_z`  in  1 each  ALU flag results
- `pc`  out  PC_W  ROM address
- `instr`  out  INSTR_W  instruction register
- `phase`  out  1  0 = FETCH, 1 = EXEC
- `dec_in`  out  7  `{instr[7:4], c_flag, z_flag, phase}`, combinational from registers
- `c_flag`, `z_flag`  out  1 each  flag register
- `halted`  out  1  high while in STOP

## Operation
- States: STOP, FETCH, EXEC. `phase` = (state == EXEC).
- Reset (async, `reset_n`=0): state=STOP, `pc`=0, `instr`=0, flags=0, `phase`=0, `halted`=1, `dec_in`=0.
- STOP → FETCH when `run`=1 or an accepted `step`. FETCH → EXEC unconditionally. EXEC → FETCH if `run`=1, else → STOP.
- FETCH edge: `instr` ← `prog_byte`. PC update applies.
- PC update, in FETCH and EXEC only, never in STOP. `dec_pc_load` has priority and gives `pc` ← `jump_addr`. Otherwise `dec_pc_inc` gives `pc` ← `pc`+1, modulo 2^PC_W, so 0xFFF wraps to 0x000. Otherwise `pc` holds.
- Flags: updated only on the EXEC edge with `dec_flags_we`=1. Strobes in FETCH or STOP are ignored.
- Strobes are sampled on the same edge as the state transition. Simultaneous `dec_pc_load` and `dec_pc_inc` performs the load only.
- `run` dropping mid-instruction completes the EXEC cycle. The machine never stops between FETCH and EXEC.
- Async reset mid-instruction discards the in-flight instruction. Restart begins at pc=0.

## Timing
- One instruction = 2 clocks. `dec_in` is valid for EXEC during the cycle that `phase`=1.
- `prog_byte` must be valid combinationally during the FETCH cycle (asynchronous ROM, zero wait states).
- STOP → first FETCH: 1 clock after `run` rises.
- `halted` is registered and rises on the edge entering STOP.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined: in STOP, a `step`=1 cycle starts exactly one FETCH+EXEC pair, then returns to STOP. A `step` during FETCH/EXEC is ignored and not queued. If `run` and `step` arrive together, `run` wins.
- Not defined: the `step` port exists but is unused. The STOP exit condition is `run` only.

## Structure
- Shared package `proc_pkg`: state enum (`ST_STOP`, `ST_FETCH`, `ST_EXEC`), `PC_W`/`INSTR_W` defaults, and `dec_in` bit-position constants (`DEC_PHASE`=0, `DEC_Z`=1, `DEC_C`=2, `DEC_OP_LSB`=3).
- One sub-module: `pc_reg`, containing the PC with load/increment priority and wrap.

## Test plan
- Reset, then `run`=1 with ROM[0]=0x3A and no strobes → cycle 1: `phase`=0; cycle 2: `instr`=0x3A, `phase`=1, `dec_in`=0b0011001.
- `dec_pc_inc` in FETCH for 4 instructions → `pc` reads 1,2,3,4. Preload `pc`=0xFFF, then inc → 0x000.
- EXEC with `dec_pc_load`=1, `dec_pc_inc`=1, `jump_addr`=0x123 → `pc`=0x123.
- `dec_flags_we` with `alu_c`=1, `alu_z`=0 in EXEC → `c_flag`=1, `z_flag`=0. Same strobe in FETCH → flags unchanged.
- `run` deasserted during FETCH → EXEC completes, STOP entered, `halted`=1, `pc` frozen. With `SEQ_SINGLE_STEP_EN`: a `step` pulse gives exactly 2 active cycles, then back to `halted`=1.
- `reset_n` low mid-EXEC → all outputs 0 and `halted`=1 immediately, without waiting for a clock edge.
